// File: rtl/std_cache_pkg.sv
// Shared cache-side types for the bypass path.
//   bypass_req_t : request from a cache-side requester toward the bypass adapter
//   bypass_rsp_t : grant / read-data response back to the requester
package std_cache_pkg;

   localparam int BYP_ADDR_W = 64;
   localparam int BYP_DATA_W = 64;
   localparam int BYP_ID_W   = 4;

   typedef enum logic [3:0] {
      AMO_NONE = 4'h0,
      AMO_LR   = 4'h1,
      AMO_SC   = 4'h2,
      AMO_SWAP = 4'h3,
      AMO_ADD  = 4'h4,
      AMO_AND  = 4'h5,
      AMO_OR   = 4'h6,
      AMO_XOR  = 4'h7,
      AMO_MAX  = 4'h8,
      AMO_MAXU = 4'h9,
      AMO_MIN  = 4'hA,
      AMO_MINU = 4'hB,
      AMO_CAS1 = 4'hC,
      AMO_CAS2 = 4'hD
   } amo_t;

   typedef struct packed {
      logic                    req;
      logic [1:0]              reqtype;
      logic [3:0]              acetype;
      amo_t                    amo;
      logic [BYP_ID_W-1:0]     id;
      logic [BYP_ADDR_W-1:0]   addr;
      logic [BYP_DATA_W-1:0]   wdata;
      logic                    we;
      logic [BYP_DATA_W/8-1:0] be;
      logic [1:0]              size;
   } bypass_req_t;

   typedef struct packed {
      logic                  gnt;
      logic                  valid;
      logic [BYP_DATA_W-1:0] rdata;
   } bypass_rsp_t;

endpackage

// File: rtl/std_bypass_arbiter_rr_select.sv
// Round-robin priority encoder: returns the first set bit of req at or above
// index rr, scanning upward and wrapping modulo NR_PORTS.
//   req : request vector, one bit per port
//   rr  : start index of the scan
//   idx : winning port index (0 when none)
//   any : at least one request present
module std_bypass_arbiter_rr_select #(
   parameter int NR_PORTS = 3,
   parameter int IDX_W    = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
   input  logic [NR_PORTS-1:0] req,
   input  logic [IDX_W-1:0]    rr,
   output logic [IDX_W-1:0]    idx,
   output logic                any
);

   always_comb begin
      int p;
      p   = 0;
      idx = '0;
      any = 1'b0;
      for (int k = 0; k < NR_PORTS; k++) begin
         p = int'(rr) + k;
         if (p >= NR_PORTS) p = p - NR_PORTS;
         if (!any && req[p]) begin
            any = 1'b1;
            idx = IDX_W'(p);
         end
      end
   end

endmodule

// File: rtl/std_bypass_arbiter.sv
// Bypass arbiter: multiplexes NR_PORTS cache-side bypass requesters onto the
// single downstream bypass adapter, one transaction outstanding at a time,
// round-robin fairness.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   req_i  : per-port upstream requests
//   rsp_o  : per-port gnt/valid/rdata (zero on every non-selected port)
//   req_o  : request to the downstream adapter
//   rsp_i  : downstream gnt/valid/rdata
//   busy_o : a transaction is in flight (state not IDLE)
module std_bypass_arbiter
   import std_cache_pkg::*;
#(
   parameter int NR_PORTS = 3
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  bypass_req_t [NR_PORTS-1:0] req_i,
   output bypass_rsp_t [NR_PORTS-1:0] rsp_o,
   output bypass_req_t                req_o,
   input  bypass_rsp_t                rsp_i,
   output logic                       busy_o
);

   localparam int IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_e;

   state_e             state_q;
   logic [IDX_W-1:0]   sel_q;
   logic [IDX_W-1:0]   rr_q;
   logic [NR_PORTS-1:0] req_vec;
   logic [IDX_W-1:0]   win_idx;
   logic               win_any;
   logic               stray_rsp;
   logic               req_drop;

   function automatic logic [IDX_W-1:0] next_port(input logic [IDX_W-1:0] p);
      return (int'(p) == NR_PORTS - 1) ? '0 : p + 1'b1;
   endfunction

   for (genvar i = 0; i < NR_PORTS; i++) begin : g_req_vec
      assign req_vec[i] = req_i[i].req;
   end

   std_bypass_arbiter_rr_select #(
      .NR_PORTS (NR_PORTS),
      .IDX_W    (IDX_W)
   ) u_rr_select (
      .req (req_vec),
      .rr  (rr_q),
      .idx (win_idx),
      .any (win_any)
   );

   // Arbitration is registered in IDLE, so req_o only rises the cycle after
   // a request is seen; this keeps the adapter path off the encoder.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         sel_q   <= '0;
         rr_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (win_any) begin
                  sel_q   <= win_idx;
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (rsp_i.gnt) begin
                  if (rsp_i.valid) begin
                     state_q <= IDLE;
                     rr_q    <= next_port(sel_q);
                  end else begin
                     state_q <= WAIT_RSP;
                  end
               end
            end
            WAIT_RSP: begin
               if (rsp_i.valid) begin
                  state_q <= IDLE;
                  rr_q    <= next_port(sel_q);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      req_o = '0;
      if (state_q == REQ) req_o = req_i[sel_q];
   end

   // Only the selected port ever sees a non-zero response; valid outside an
   // outstanding transaction never reaches any port.
   always_comb begin
      rsp_o = '0;
      for (int i = 0; i < NR_PORTS; i++) begin
         if (sel_q == IDX_W'(i)) begin
            if (state_q == REQ) begin
               rsp_o[i].gnt = rsp_i.gnt;
               if (rsp_i.gnt && rsp_i.valid) begin
                  rsp_o[i].valid = 1'b1;
                  rsp_o[i].rdata = rsp_i.rdata;
               end
            end else if (state_q == WAIT_RSP && rsp_i.valid) begin
               rsp_o[i].valid = 1'b1;
               rsp_o[i].rdata = rsp_i.rdata;
            end
         end
      end
   end

   assign busy_o = (state_q != IDLE);

   assign stray_rsp = rsp_i.valid &&
                      ((state_q == IDLE) || (state_q == REQ && !rsp_i.gnt));
   assign req_drop  = (state_q == REQ) && !req_i[sel_q].req;

   a_stray_rsp : assert property (@(posedge clk_i) disable iff (!rst_ni) !stray_rsp)
      else $warning("std_bypass_arbiter: rsp_i.valid with no transaction outstanding, dropped");

   a_req_drop : assert property (@(posedge clk_i) disable iff (!rst_ni) !req_drop)
      else $warning("std_bypass_arbiter: selected requester dropped req before gnt");

endmodule

// File: tb/tb_std_bypass_arbiter.sv
module tb_std_bypass_arbiter;
   import std_cache_pkg::*;

   localparam int N = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bypass_req_t [N-1:0] req_i;
   bypass_rsp_t [N-1:0] rsp_o;
   bypass_req_t         req_o;
   bypass_rsp_t         rsp_i;
   logic                busy;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int          port;
      logic [63:0] rdata;
   } exp_t;
   exp_t sb[$];
   logic [63:0] rd_next = 64'hC0DE_0000_0000_0000;

   std_bypass_arbiter #(.NR_PORTS(N)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .req_i  (req_i),
      .rsp_o  (rsp_o),
      .req_o  (req_o),
      .rsp_i  (rsp_i),
      .busy_o (busy)
   );

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic mk_req(input int p, input logic we, input logic [63:0] addr);
      req_i[p]         = '0;
      req_i[p].req     = 1'b1;
      req_i[p].reqtype = 2'(p);
      req_i[p].acetype = 4'(p + 5);
      req_i[p].amo     = we ? AMO_NONE : AMO_ADD;
      req_i[p].id      = 4'(p);
      req_i[p].addr    = addr;
      req_i[p].wdata   = addr ^ 64'h5555_AAAA_5555_AAAA;
      req_i[p].we      = we;
      req_i[p].be      = 8'hFF;
      req_i[p].size    = 2'd3;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      rsp_i = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // One cycle with a downstream adapter that grants and answers immediately.
   // Pops the scoreboard on any rsp_o valid; returns the completed port or -1.
   task automatic cycle_auto(output int done);
      exp_t e;
      done  = -1;
      rsp_i = '0;
      #1;
      if (req_o.req) begin
         rsp_i.gnt   = 1'b1;
         rsp_i.valid = 1'b1;
         rsp_i.rdata = rd_next;
         rd_next     = rd_next + 64'd1;
      end
      @(negedge clk);
      for (int p = 0; p < N; p++) begin
         if (rsp_o[p].valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL sb_unexpected: port %0d valid, nothing expected", p);
            end else begin
               e = sb.pop_front();
               if (p !== e.port || rsp_o[p].rdata !== e.rdata) begin
                  n_err++;
                  $display("FAIL sb_order: got port %0d rdata %h, want port %0d rdata %h",
                           p, rsp_o[p].rdata, e.port, e.rdata);
               end
               done = p;
            end
         end
      end
      for (int p = 0; p < N; p++) begin
         if (p != done) begin
            n_cmp++;
            if (rsp_o[p] !== '0) begin
               n_err++;
               $display("FAIL idle_port_zero: port %0d rsp %h, want 0", p, rsp_o[p]);
            end
         end
      end
      @(posedge clk);
      #1 rsp_i = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_i = '0;
      rsp_i = '0;
      mk_req(0, 1'b0, 64'h1000);
      repeat (2) @(negedge clk);
      n_cmp++; if (req_o !== '0) begin n_err++; $display("FAIL reset_req_o: %h want 0", req_o); end
      n_cmp++; if (rsp_o !== '0) begin n_err++; $display("FAIL reset_rsp_o: %h want 0", rsp_o); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: %b want 0", busy); end
      n_cmp++; if (dut.rr_q !== 2'd0) begin n_err++; $display("FAIL reset_rr: %0d want 0", dut.rr_q); end
      n_cmp++; if (dut.sel_q !== 2'd0) begin n_err++; $display("FAIL reset_sel: %0d want 0", dut.sel_q); end
      req_i = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_single_read();
      exp_t e;
      mk_req(1, 1'b0, 64'h8000_0010);
      sb.push_back('{1, 64'hDEAD_BEEF});
      for (int c = 1; c <= 6; c++) begin
         rsp_i = '0;
         if (c == 3) rsp_i.gnt = 1'b1;
         if (c == 5) begin rsp_i.valid = 1'b1; rsp_i.rdata = 64'hDEAD_BEEF; end
         if (c >= 4) req_i[1].req = 1'b0;
         @(negedge clk);
         n_cmp++;
         if (req_o.req !== (c == 2 || c == 3)) begin
            n_err++; $display("FAIL read_req_o c%0d: %b want %b", c, req_o.req, (c == 2 || c == 3));
         end
         n_cmp++;
         if (rsp_o[1].gnt !== (c == 3)) begin
            n_err++; $display("FAIL read_gnt c%0d: %b want %b", c, rsp_o[1].gnt, (c == 3));
         end
         if (c == 2) begin
            n_cmp++;
            if (req_o.addr !== 64'h8000_0010 || req_o.id !== 4'd1) begin
               n_err++; $display("FAIL read_addr: %h id %0d want 80000010 id 1", req_o.addr, req_o.id);
            end
         end
         n_cmp++;
         if (rsp_o[1].valid !== (c == 5)) begin
            n_err++; $display("FAIL read_valid c%0d: %b want %b", c, rsp_o[1].valid, (c == 5));
         end else if (c == 5) begin
            e = sb.pop_front();
            n_cmp++;
            if (rsp_o[1].rdata !== e.rdata) begin
               n_err++; $display("FAIL read_rdata: %h want %h", rsp_o[1].rdata, e.rdata);
            end
         end
         if (c == 6) begin
            n_cmp++; if (dut.rr_q !== 2'd2) begin n_err++; $display("FAIL read_rr: %0d want 2", dut.rr_q); end
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL read_busy_end: %b want 0", busy); end
         end
         @(posedge clk);
         #1;
      end
      rsp_i = '0;
   endtask

   task automatic test_contention();
      int done;
      int cnt;
      cnt = 0;
      rst_n = 1'b0;
      for (int p = 0; p < N; p++) mk_req(p, 1'b0, 64'h2000 + 64'(p * 64));
      do_reset();
      sb.push_back('{0, rd_next});
      sb.push_back('{1, rd_next + 64'd1});
      sb.push_back('{2, rd_next + 64'd2});
      sb.push_back('{0, rd_next + 64'd3});
      for (int c = 0; c < 20 && cnt < 4; c++) begin
         cycle_auto(done);
         if (done >= 0) cnt++;
      end
      req_i = '0;
      n_cmp++;
      if (cnt !== 4) begin n_err++; $display("FAIL contention_count: %0d done want 4", cnt); end
      n_cmp++;
      if (dut.rr_q !== 2'd1) begin n_err++; $display("FAIL contention_rr: %0d want 1", dut.rr_q); end
      sb.delete();
   endtask

   task automatic test_wrap();
      int done;
      int cnt;
      int exp_rr [2];
      exp_rr[0] = 0;
      exp_rr[1] = 1;
      mk_req(1, 1'b0, 64'h3000);
      sb.push_back('{1, rd_next});
      done = -1;
      for (int c = 0; c < 10 && done < 0; c++) cycle_auto(done);
      req_i[1].req = 1'b0;
      n_cmp++;
      if (dut.rr_q !== 2'd2) begin n_err++; $display("FAIL wrap_setup_rr: %0d want 2", dut.rr_q); end
      mk_req(0, 1'b0, 64'h4000);
      mk_req(2, 1'b0, 64'h4040);
      sb.push_back('{2, rd_next});
      sb.push_back('{0, rd_next + 64'd1});
      cnt = 0;
      for (int c = 0; c < 20 && cnt < 2; c++) begin
         cycle_auto(done);
         if (done >= 0) begin
            req_i[done].req = 1'b0;
            n_cmp++;
            if (int'(dut.rr_q) !== exp_rr[cnt]) begin
               n_err++; $display("FAIL wrap_rr%0d: %0d want %0d", cnt, dut.rr_q, exp_rr[cnt]);
            end
            cnt++;
         end
      end
      n_cmp++;
      if (cnt !== 2) begin n_err++; $display("FAIL wrap_count: %0d done want 2", cnt); end
      req_i = '0;
      sb.delete();
   endtask

   task automatic test_same_cycle();
      exp_t e;
      mk_req(0, 1'b1, 64'h5000);
      sb.push_back('{0, 64'h0123_4567_89AB_CDEF});
      rsp_i = '0;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL same_idle_busy: %b want 0", busy); end
      @(posedge clk);
      #1;
      rsp_i.gnt   = 1'b1;
      rsp_i.valid = 1'b1;
      rsp_i.rdata = 64'h0123_4567_89AB_CDEF;
      @(negedge clk);
      n_cmp++;
      if (rsp_o[0].gnt !== 1'b1 || rsp_o[0].valid !== 1'b1) begin
         n_err++; $display("FAIL same_gnt_valid: gnt %b valid %b want 1 1", rsp_o[0].gnt, rsp_o[0].valid);
      end
      e = sb.pop_front();
      n_cmp++;
      if (rsp_o[0].rdata !== e.rdata) begin
         n_err++; $display("FAIL same_rdata: %h want %h", rsp_o[0].rdata, e.rdata);
      end
      n_cmp++;
      if (req_o.we !== 1'b1 || req_o.be !== 8'hFF) begin
         n_err++; $display("FAIL same_we_be: we %b be %h want 1 ff", req_o.we, req_o.be);
      end
      @(posedge clk);
      #1;
      rsp_i = '0;
      req_i[0].req = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL same_next_idle: busy %b want 0", busy); end
      n_cmp++; if (rsp_o !== '0) begin n_err++; $display("FAIL same_next_rsp: %h want 0", rsp_o); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_wait();
      mk_req(1, 1'b0, 64'h6000);
      rsp_i = '0;
      @(posedge clk);
      #1 rsp_i.gnt = 1'b1;
      @(posedge clk);
      #1 rsp_i = '0;
      req_i[1].req = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstw_busy_wait: %b want 1", busy); end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstw_async_busy: %b want 0", busy); end
      n_cmp++; if (req_o !== '0 || rsp_o !== '0) begin n_err++; $display("FAIL rstw_async_outs: req %h rsp %h want 0", req_o, rsp_o); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rsp_i.valid = 1'b1;
      rsp_i.rdata = 64'h1234_5678;
      @(negedge clk);
      for (int p = 0; p < N; p++) begin
         n_cmp++;
         if (rsp_o[p].valid !== 1'b0) begin n_err++; $display("FAIL rstw_stray_valid: port %0d valid %b want 0", p, rsp_o[p].valid); end
      end
      n_cmp++; if (dut.stray_rsp !== 1'b1) begin n_err++; $display("FAIL rstw_flag: %b want 1", dut.stray_rsp); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstw_busy: %b want 0", busy); end
      n_cmp++; if (dut.rr_q !== 2'd0) begin n_err++; $display("FAIL rstw_rr: %0d want 0", dut.rr_q); end
      @(posedge clk);
      #1 rsp_i = '0;
   endtask

   task automatic test_backpressure();
      bypass_req_t exp_req;
      exp_t        e;
      mk_req(0, 1'b0, 64'h7000_0040);
      mk_req(2, 1'b1, 64'h7000_0080);
      exp_req = req_i[0];
      sb.push_back('{0, 64'hFEED_F00D});
      rsp_i = '0;
      @(posedge clk);
      #1;
      for (int c = 0; c < 20; c++) begin
         if (c == 10) req_i[2].addr = 64'h7000_00C0;
         @(negedge clk);
         n_cmp++;
         if (req_o !== exp_req) begin n_err++; $display("FAIL bp_req_o c%0d: %h want %h", c, req_o, exp_req); end
         n_cmp++;
         if (busy !== 1'b1) begin n_err++; $display("FAIL bp_busy c%0d: %b want 1", c, busy); end
         n_cmp++;
         if (rsp_o !== '0) begin n_err++; $display("FAIL bp_no_grant c%0d: %h want 0", c, rsp_o); end
         @(posedge clk);
         #1;
      end
      req_i[2].req = 1'b0;
      rsp_i.gnt   = 1'b1;
      rsp_i.valid = 1'b1;
      rsp_i.rdata = 64'hFEED_F00D;
      @(negedge clk);
      n_cmp++;
      if (rsp_o[0].valid !== 1'b1) begin
         n_err++; $display("FAIL bp_final_valid: %b want 1", rsp_o[0].valid);
      end else begin
         e = sb.pop_front();
         n_cmp++;
         if (rsp_o[0].rdata !== e.rdata) begin n_err++; $display("FAIL bp_final_rdata: %h want %h", rsp_o[0].rdata, e.rdata); end
      end
      n_cmp++;
      if (rsp_o[2] !== '0) begin n_err++; $display("FAIL bp_port2_zero: %h want 0", rsp_o[2]); end
      @(posedge clk);
      #1;
      rsp_i = '0;
      req_i = '0;
      @(negedge clk);
      n_cmp++; if (dut.rr_q !== 2'd1) begin n_err++; $display("FAIL bp_rr: %0d want 1", dut.rr_q); end
      sb.delete();
   endtask

   initial begin
      req_i = '0;
      rsp_i = '0;
      test_reset();
      test_single_read();
      test_contention();
      test_wrap();
      test_same_cycle();
      test_reset_wait();
      test_backpressure();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
